dm_responder: RTL
=================

// Module: dm_responder
// PURPOSE
//   Word-organised data-memory slave answering load/store requests issued by the CPU M stage.
//   It replaces the single-cycle DM with a valid/ready request/response pair and a configurable access latency.
//   The CPU must stall M until the response arrives.
//   Exactly one outstanding access at a time; byte lanes are selected by byte enables.
// PARAMETERS
//   ADDR_WIDTH  12            word-index bits; capacity = 2**ADDR_WIDTH words
//   BASE_ADDR   32'h00000000  byte address of word 0 (must be word-aligned)
//   LATENCY     2             edges from request accept to access commit; legal range 1..15
// PORTS
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous, active-low reset (reset==0 resets)
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept a request (high only in IDLE)
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address; bits [1:0] are ignored
//   req_be      in   4   store byte enables; be[i] selects wdata[8i+7:8i]
//   req_wdata   in   32  store data, already lane-aligned by the CPU
//   resp_valid  out  1   response present
//   resp_ready  in   1   CPU accepts the response
//   resp_rdata  out  32  full word read; 0 for stores and for errors
//   resp_err    out  1   address out of range, or store with be==4'b0000
// BEHAVIOUR
// - Reset (reset==0 at an edge):
//   - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
//   - All memory words are cleared to 0.
//   - Any pending access is dropped; an uncommitted store is never written.
// - req_ready = (state==IDLE). It is high in the first cycle after reset is released.
// - FSM with states IDLE, WAIT, RESP:
//   - IDLE: at an edge with req_valid && req_ready, capture we, addr, be and wdata; load cnt=LATENCY-1; go to WAIT.
//     - Request inputs are sampled only at that accept edge; later changes to them are ignored.
//   - WAIT: if cnt!=0, cnt<=cnt-1. If cnt==0, commit the access at this edge and go to RESP.
//     - Commit happens exactly LATENCY edges after the accept edge.
//   - RESP: resp_valid=1. resp_rdata and resp_err stay stable until the handshake.
//     - At an edge with resp_valid && resp_ready, go to IDLE; resp_valid, resp_rdata and resp_err return to 0.
//     - Back-pressure: the FSM may stay in RESP indefinitely; the held outputs must not change.
// - Commit and address rules:
//   - idx = (addr - BASE_ADDR) >> 2. The access is in range iff addr >= BASE_ADDR && idx < 2**ADDR_WIDTH.
//     - Range check uses 32-bit unsigned compare; no wrap-around into the array.
//   - Store in range with be!=0: mem[idx][8i+7:8i] <= wdata[8i+7:8i] for each be[i]==1; other lanes are unchanged.
//     - resp_rdata=0, resp_err=0.
//   - Load in range: resp_rdata = mem[idx] (the whole word; be ignored); resp_err=0.
//   - Out of range, or store with be==0: no memory change; resp_rdata=0, resp_err=1.
// - Ordering: a store commits before its response. Any later load observes it (read-after-write coherent).
// - Minimum request-to-request spacing is LATENCY+2 cycles with resp_ready tied high.
//   There is no accept in the same cycle as a response handshake.
// - Reset asserted during WAIT or RESP overrides everything above.
// - Latency: first resp_valid cycle = accept edge + LATENCY edges. Observed request-to-response = LATENCY+1 cycles.
// TESTING
//   1. Release reset, then load addr 0x10 with LATENCY=2:
//      req_ready=1 on the first cycle; resp_valid rises 2 edges after accept; rdata=0, err=0.
//   2. Store 0xDEADBEEF with be=1111 to 0x20, then load 0x20 -> rdata=0xDEADBEEF.
//      Then store 0x00001100 with be=0010 and load again -> rdata=0xDEAD11EF.
//   3. Hold resp_ready=0 for 5 cycles during a load:
//      resp_valid, rdata and err stay constant; req_ready=0 throughout; after the handshake req_ready=1 the next cycle.
//   4. Load from BASE_ADDR+4*2**ADDR_WIDTH -> err=1, rdata=0. Store with be=0000 to 0x0 -> err=1, mem[0] unchanged.
//   5. Store 0x12345678 to 0x40; assert reset while in WAIT before commit; after release, load 0x40 -> rdata=0.
//   6. Change req_addr and req_wdata in the cycle after accept -> the original captured values are used.

Source files
------------

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_responder
//  Purpose  : Word-organised data-memory slave with valid/ready request and
//             response channels and a fixed, configurable access latency.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] word_q, word_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [29:0]           off;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  commit;
  logic                  bad;
  logic                  do_write;
  logic [31:0]           cur_word;
  logic [31:0]           merged;
  logic                  unused_ok;

  // Byte-address bits [1:0] carry no meaning for a word-organised memory.
  assign unused_ok = ^req_addr[1:0];

  // Range check on word addresses; the subtraction only matters once word_q >= BASE_WORD.
  assign off      = word_q - BASE_WORD;
  assign in_range = (word_q >= BASE_WORD) && ((off >> ADDR_WIDTH) == '0);
  assign idx      = off[ADDR_WIDTH-1:0];
  assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign bad      = !in_range || (we_q && (be_q == 4'b0000));
  assign do_write = commit && we_q && !bad;
  assign cur_word = mem_q[idx];
  assign merged   = {be_q[3] ? wdata_q[31:24] : cur_word[31:24],
                     be_q[2] ? wdata_q[23:16] : cur_word[23:16],
                     be_q[1] ? wdata_q[15:8]  : cur_word[15:8],
                     be_q[0] ? wdata_q[7:0]   : cur_word[7:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    word_d       = word_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          word_d  = req_addr[31:2];
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          err_d        = bad;
          rdata_d      = (!bad && !we_q) ? cur_word : 32'd0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = 32'd0;
          err_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      word_q       <= 30'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      for (logic [ADDR_WIDTH:0] i = '0; i < (ADDR_WIDTH+1)'(DEPTH); i++) begin
        mem_q[i[ADDR_WIDTH-1:0]] <= 32'd0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      word_q       <= word_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      if (do_write) begin
        mem_q[idx] <= merged;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire
